// File: rtl/aes_core_scheduler_if.sv
// Request/response bundle between system masters and the AES core scheduler.
// Requester r uses bits [128r+127:128r] of req_plaintext and req_key.
interface aes_core_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_plaintext;
    logic [NUM_REQ*128-1:0] req_key;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_err;

    // Requesters drive requests and accept responses.
    modport master (
        output req_valid, req_plaintext, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    // The scheduler accepts requests and produces responses.
    modport slave (
        input  req_valid, req_plaintext, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one AES128 core among NUM_REQ requesters.
// A granted 128-bit plaintext/key pair is sent to the core as 4 words (MSW
// first); the 4 returned words are packed {w0,w1,w2,w3} into a tagged response.
// A watchdog in WAIT turns a silent core into an error response.
//
// Handshakes: a request transfers on the rising edge where req_valid[r] and
// req_ready[r] are both high; a response transfers on the rising edge where
// rsp_valid and rsp_ready are both high. rsp_data/rsp_id/rsp_err are held
// stable while rsp_valid is high and rsp_ready is low.
module aes_core_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_core_scheduler_if.slave   bus,
    output logic                  core_dv_out,
    output logic [DATA_WIDTH-1:0] core_pt_out,
    output logic [DATA_WIDTH-1:0] core_key_out,
    input  logic [DATA_WIDTH-1:0] core_data_in,
    input  logic                  core_dv_in,
    output logic                  busy,
    output logic [2:0]            dbg_state
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_COLLECT = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  last_grant_q;
    logic [ID_W-1:0]  id_q;
    logic [127:0]     pt_q, key_q, data_q;
    logic [1:0]       word_cnt_q;
    logic [WD_W-1:0]  wd_cnt_q;
    logic             err_q;

    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [127:0]       sel_pt, sel_key;
    logic               timeout;

    assign timeout = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Round-robin pick: first valid requester at or after last_grant+1.
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        sel_pt     = '0;
        sel_key    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!gnt_any && bus.req_valid[r] &&
                    (((int'(last_grant_q) + 1 + off) % NUM_REQ) == r)) begin
                    gnt_any       = 1'b1;
                    gnt_idx       = ID_W'(r);
                    gnt_onehot[r] = 1'b1;
                    sel_pt        = bus.req_plaintext[r*128 +: 128];
                    sel_key       = bus.req_key[r*128 +: 128];
                end
            end
        end
    end

    // State register; reset drops straight back to IDLE from anywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (gnt_any) state_d = S_LOAD;
            S_LOAD:    if (word_cnt_q == 2'd3) state_d = S_WAIT;
            S_WAIT: begin
                if (core_dv_in)   state_d = S_COLLECT;
                else if (timeout) state_d = S_RESP;
            end
            S_COLLECT: if (core_dv_in && word_cnt_q == 2'd3) state_d = S_RESP;
            S_RESP:    if (bus.rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the grant, shift words out to the core, shift results in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            data_q       <= '0;
            word_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        pt_q         <= sel_pt;
                        key_q        <= sel_key;
                        id_q         <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        word_cnt_q   <= 2'd0;
                        err_q        <= 1'b0;
                    end
                end
                S_LOAD: begin
                    pt_q       <= {pt_q[95:0], 32'h0};
                    key_q      <= {key_q[95:0], 32'h0};
                    word_cnt_q <= word_cnt_q + 2'd1;
                    wd_cnt_q   <= '0;
                    data_q     <= '0;
                end
                S_WAIT: begin
                    if (core_dv_in) begin
                        data_q     <= {data_q[95:0], core_data_in};
                        word_cnt_q <= 2'd1;
                    end else if (timeout) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                end
                S_COLLECT: begin
                    if (core_dv_in) begin
                        data_q     <= {data_q[95:0], core_data_in};
                        word_cnt_q <= word_cnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; req_ready is gated by rst_n so it is 0 in reset.
    assign core_dv_out   = (state_q == S_LOAD);
    assign core_pt_out   = core_dv_out ? pt_q[127 -: DATA_WIDTH]  : '0;
    assign core_key_out  = core_dv_out ? key_q[127 -: DATA_WIDTH] : '0;
    assign bus.req_ready = (state_q == S_IDLE && rst_n) ? gnt_onehot : '0;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;
endmodule
